// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: continuous round-robin ADC channel scanner driving an SPI master, with a per-channel result table.
// Optional frame watchdog (timeout_err) is built only when ADC_SCAN_TIMEOUT_EN is defined.
module adc_scan_ctrl #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    output logic        spi_start,
    output logic [15:0] spi_data_in,
    input  logic        spi_busy,
    input  logic        spi_new_data,
    input  logic [15:0] spi_data_out,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic        scan_done,
    output logic        timeout_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DATA, STORE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  addr_q, addr_d, prev_q, prev_d;
    logic        prime_q, prime_d, got_q, got_d;
    logic [11:0] data_q, data_d;
    logic [11:0] tab_q [8];
    logic        wr, to_hit, unused_ok;

    function automatic logic [2:0] lo_bit(input logic [7:0] m);
        lo_bit = 3'd0;
        for (int i = 7; i >= 0; i--) if (m[i]) lo_bit = 3'(i);
    endfunction

    function automatic logic [2:0] hi_bit(input logic [7:0] m);
        hi_bit = 3'd0;
        for (int i = 0; i < 8; i++) if (m[i]) hi_bit = 3'(i);
    endfunction

    // Smallest set channel above c, wrapping to the lowest set channel.
    function automatic logic [2:0] next_ch(input logic [2:0] c, input logic [7:0] m);
        next_ch = lo_bit(m);
        for (int i = 7; i >= 0; i--) if (m[i] && i > int'(c)) next_ch = 3'(i);
    endfunction

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        addr_d       = addr_q;
        prev_d       = prev_q;
        prime_d      = prime_q;
        got_d        = got_q;
        data_d       = data_q;
        wr           = 1'b0;
        spi_start    = 1'b0;
        sample_valid = 1'b0;
        scan_done    = 1'b0;
        case (state_q)
            IDLE: if (enable && ch_mask != 8'h00) begin
                state_d = ISSUE;
                mask_d  = ch_mask;
                addr_d  = lo_bit(ch_mask);
                prime_d = 1'b1;
            end
            ISSUE: if (!spi_busy) begin
                spi_start = 1'b1;
                got_d     = 1'b0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A frame may finish before busy is ever seen; remember its data.
                if (spi_new_data) begin
                    got_d  = 1'b1;
                    data_d = spi_data_out[11:0];
                end
                if (spi_busy || spi_new_data) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (spi_new_data) data_d = spi_data_out[11:0];
                if (spi_new_data || got_q) state_d = STORE;
            end
            STORE: begin
                wr           = !prime_q;
                sample_valid = !prime_q;
                scan_done    = !prime_q && prev_q == hi_bit(mask_q);
                mask_d       = scan_done ? ch_mask : mask_q;
                addr_d       = next_ch(addr_q, mask_d);
                prev_d       = addr_q;
                prime_d      = 1'b0;
                state_d      = (enable && mask_d != 8'h00) ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (to_hit) begin
            state_d = IDLE;
            prime_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= 8'h00;
            addr_q  <= 3'd0;
            prev_q  <= 3'd0;
            prime_q <= 1'b1;
            got_q   <= 1'b0;
            data_q  <= 12'h000;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            prev_q  <= prev_d;
            prime_q <= prime_d;
            got_q   <= got_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) tab_q[i] <= 12'h000;
        end else if (wr) begin
            tab_q[prev_q] <= data_q;
        end
    end

`ifdef ADC_SCAN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    // cnt_q reads k on the k-th cycle after spi_start, so the flag shows TIMEOUT_CYC cycles after it.
    assign to_hit = (state_q == WAIT_BUSY || state_q == WAIT_DATA) && cnt_q >= CW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == ISSUE) ? CW'(1) : cnt_q + CW'(1);
            if (to_hit) err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign unused_ok   = ^{spi_data_out[15:12], TIMEOUT_CYC != 0};
    assign spi_data_in = {2'b00, addr_q, 11'b0};
    assign sample_ch   = prev_q;
    assign sample_data = data_q;
    assign rd_data     = tab_q[rd_ch];
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed + randomized checks of adc_scan_ctrl against a pipelined ADC/SPI model.
// Define ADC_SCAN_TIMEOUT_EN to also exercise the frame watchdog.
module tb_adc_scan_ctrl;
`ifdef ADC_SCAN_TIMEOUT_EN
    localparam int TO = 15;
`else
    localparam int TO = 1023;
`endif

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic        spi_start;
    logic [15:0] spi_data_in;
    logic        spi_busy = 1'b0, spi_new_data = 1'b0;
    logic [15:0] spi_data_out = 16'h0000;
    logic [2:0]  rd_ch = 3'd0;
    logic [11:0] rd_data;
    logic        sample_valid, scan_done, timeout_err;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;

    always #5 clk = ~clk;

    adc_scan_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_busy(spi_busy),
        .spi_new_data(spi_new_data), .spi_data_out(spi_data_out),
        .rd_ch(rd_ch), .rd_data(rd_data), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .sample_data(sample_data),
        .scan_done(scan_done), .timeout_err(timeout_err)
    );

    logic [11:0] adc_val [8];
    logic [11:0] mtab [8];
    logic [2:0]  cur_a = 3'd0, last_a = 3'd0;
    int          rem = 0;
    bit          mute = 1'b0;
    int          n_start = 0, stray = 0, lat_bad = 0, fmt_bad = 0;
    logic        nd_prev = 1'b0;
    logic [2:0]  q_ch[$];
    logic [11:0] q_dat[$];
    bit          q_done[$];
    logic [2:0]  q_addr[$];
    int          checks = 0, errors = 0;

    // SPI master + ADC: each frame returns the conversion of the previous frame's address.
    always @(posedge clk) begin
        spi_new_data <= 1'b0;
        if (spi_start && !mute) begin
            cur_a    <= spi_data_in[13:11];
            rem      <= 2 + int'($urandom_range(3, 0));
            spi_busy <= 1'b1;
        end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) begin
                spi_busy     <= 1'b0;
                spi_new_data <= 1'b1;
                spi_data_out <= {4'($urandom), adc_val[last_a]};
                last_a       <= cur_a;
            end
        end
    end

    always @(negedge clk) begin
        if (sample_valid) begin
            q_ch.push_back(sample_ch);
            q_dat.push_back(sample_data);
            q_done.push_back(scan_done);
            if (!nd_prev) lat_bad++;
        end else if (scan_done) stray++;
        if (spi_start) begin
            n_start++;
            q_addr.push_back(spi_data_in[13:11]);
            if ((spi_data_in & 16'hC7FF) != 16'h0000) fmt_bad++;
        end
        nd_prev = spi_new_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tab_chk();
        for (int c = 0; c < 8; c++) begin
            rd_ch = 3'(c);
            #1;
            chk($sformatf("table[%0d]", c), 32'(rd_data), 32'(mtab[c]));
        end
    endtask

    task automatic clear_q();
        @(posedge clk);
        q_ch.delete(); q_dat.delete(); q_done.delete(); q_addr.delete();
    endtask

    task automatic wait_samples(input int n, input string tag);
        int w = 0;
        while (q_ch.size() < n && w < 500) begin @(negedge clk); w++; end
        chk(tag, 32'(q_ch.size() >= n), 32'd1);
    endtask

    task automatic wait_starts(input int n, input string tag);
        int w = 0;
        while (n_start < n && w < 500) begin @(negedge clk); w++; end
        chk(tag, 32'(n_start >= n), 32'd1);
    endtask

    // Model: frames walk the set bits ascending and cyclically from the lowest;
    // sample i carries the address of frame i, delivered after frame i+1.
    task automatic run_round(input logic [7:0] m, input int ns);
        int chans[$];
        int n, e;
        for (int c = 0; c < 8; c++) if (m[c]) chans.push_back(c);
        n = chans.size();
        clear_q();
        @(negedge clk);
        ch_mask = m;
        enable  = 1'b1;
        wait_samples(ns, "round_samples");
        enable = 1'b0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < ns && i < q_ch.size() && i < q_addr.size(); i++) begin
            e = chans[i % n];
            chk($sformatf("addr[%0d] m=%0h", i, m), 32'(q_addr[i]), 32'(e));
            chk($sformatf("ch[%0d] m=%0h", i, m), 32'(q_ch[i]), 32'(e));
            chk($sformatf("data[%0d] m=%0h", i, m), 32'(q_dat[i]), 32'(adc_val[e]));
            chk($sformatf("done[%0d] m=%0h", i, m), 32'(q_done[i]), 32'(i % n == n - 1));
        end
        foreach (chans[k]) mtab[chans[k]] = adc_val[chans[k]];
        tab_chk();
    endtask

    initial begin
        int s0, st0, k, w;
        logic [7:0] m;
        for (int c = 0; c < 8; c++) begin adc_val[c] = 12'h000; mtab[c] = 12'h000; end
        repeat (3) @(negedge clk);
        chk("rst_spi_start", 32'(spi_start), 32'd0);
        chk("rst_spi_data_in", 32'(spi_data_in), 32'h0000);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample_ch", 32'(sample_ch), 32'd0);
        chk("rst_sample_data", 32'(sample_data), 32'd0);
        chk("rst_scan_done", 32'(scan_done), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        tab_chk();
        rst = 1'b0;

        ch_mask = 8'h00;
        enable  = 1'b1;
        repeat (30) @(negedge clk);
        chk("zero_mask_no_frames", 32'(n_start), 32'd0);
        enable = 1'b0;

        for (int c = 0; c < 8; c++) adc_val[c] = 12'h100 + 12'(c);
        run_round(8'h05, 4);
        run_round(8'h80, 3);

        for (int r = 0; r < 4; r++) begin
            m = 8'($urandom_range(255, 1));
            for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
            k = 0;
            for (int c = 0; c < 8; c++) k += int'(m[c]);
            run_round(m, k + 2);
        end

        // Drop enable mid-frame: frame completes, one sample, then idle; re-enable re-primes.
        clear_q();
        @(negedge clk);
        ch_mask = 8'h06;
        enable  = 1'b1;
        wait_samples(1, "drop_first_sample");
        wait_starts(n_start + 1, "drop_next_frame");
        w = 0;
        while (!spi_busy && w < 50) begin @(negedge clk); w++; end
        chk("drop_busy_seen", 32'(spi_busy), 32'd1);
        k = q_ch.size();
        st0 = n_start;
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("drop_one_sample", 32'(q_ch.size()), 32'(k + 1));
        chk("drop_no_more_frames", 32'(n_start), 32'(st0));
        s0 = q_ch.size();
        enable = 1'b1;
        wait_starts(st0 + 2, "reen_frames");
        chk("reen_priming_no_sample", 32'(q_ch.size()), 32'(s0));
        wait_samples(s0 + 1, "reen_sample");
        if (q_ch.size() > s0) begin
            chk("reen_ch", 32'(q_ch[s0]), 32'd1);
            chk("reen_data", 32'(q_dat[s0]), 32'(adc_val[1]));
        end
        enable = 1'b0;
        repeat (40) @(negedge clk);

        // Reset in the middle of a frame; the late spi_new_data must be ignored.
        for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom_range(4095, 1));
        ch_mask = 8'hFF;
        enable  = 1'b1;
        wait_samples(2, "prerst_samples");
        w = 0;
        while (!spi_busy && w < 50) begin @(negedge clk); w++; end
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        chk("rst_async_spi_data_in", 32'(spi_data_in), 32'h0000);
        q_ch.delete(); q_dat.delete(); q_done.delete(); q_addr.delete();
        st0 = n_start;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_sample", 32'(q_ch.size()), 32'd0);
        chk("midrst_no_frames", 32'(n_start), 32'(st0));
        chk("midrst_spi_start", 32'(spi_start), 32'd0);
        for (int c = 0; c < 8; c++) mtab[c] = 12'h000;
        tab_chk();

`ifdef ADC_SCAN_TIMEOUT_EN
        mute = 1'b1;
        clear_q();
        @(negedge clk);
        ch_mask = 8'h01;
        enable  = 1'b1;
        w = 0;
        while (!spi_start && w < 50) begin @(negedge clk); w++; end
        chk("to_start_seen", 32'(spi_start), 32'd1);
        k = 0;
        while (!timeout_err && k < 60) begin @(negedge clk); k++; end
        chk("to_cycles", 32'(k), 32'd15);
        mute = 1'b0;
        st0 = n_start;
        wait_starts(st0 + 2, "to_restart");
        chk("to_priming_no_sample", 32'(q_ch.size()), 32'd0);
        chk("to_sticky", 32'(timeout_err), 32'd1);
        enable = 1'b0;
        repeat (40) @(negedge clk);
`endif

        chk("stray_scan_done", 32'(stray), 32'd0);
        chk("sample_latency", 32'(lat_bad), 32'd0);
        chk("frame_format", 32'(fmt_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
